// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch/load-store ports, the shared memory
// port and the arbiter. The arbiter connects through the slave modport.
`timescale 1ns/1ps
interface mem_arbiter_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;

  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;

  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  logic        bus_err;

  modport slave (
    input  ifu_reqValid, ifu_addr,
    output ifu_respValid, ifu_rdata,
    input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_respValid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    input  mem_respValid, mem_rdata,
    output bus_err
  );

  modport master (
    output ifu_reqValid, ifu_addr,
    input  ifu_respValid, ifu_rdata,
    output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_respValid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    output mem_respValid, mem_rdata,
    input  bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of fetch and load/store requests onto one memory port,
// one outstanding transaction at a time, with a per-transaction timeout.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        ifu_pend, lsu_pend;
  logic        last_lsu, gnt_lsu;

  logic [31:0] ifu_addr_q, lsu_addr_q, lsu_wdata_q;
  logic [1:0]  lsu_size_q;
  logic        lsu_wen_q;
  logic [3:0]  lsu_wmask_q;

  logic        mem_req_r, mem_wen_r, ifu_resp_r, lsu_resp_r, bus_err_r;
  logic [31:0] mem_addr_r, mem_wdata_r, ifu_rdata_r, lsu_rdata_r;
  logic [1:0]  mem_size_r;
  logic [3:0]  mem_wmask_r;

  logic        ifu_req, lsu_req, grant, pick_lsu, wait_done;
  logic [31:0] ifu_addr_sel, lsu_addr_sel, lsu_wdata_sel, rsp_data;
  logic [1:0]  lsu_size_sel;
  logic        lsu_wen_sel;
  logic [3:0]  lsu_wmask_sel;

  // A pulse arriving in an arbitration cycle competes directly with its live fields.
  assign ifu_req  = ifu_pend | bus.ifu_reqValid;
  assign lsu_req  = lsu_pend | bus.lsu_reqValid;
  assign grant    = (state != WAIT) && (ifu_req || lsu_req);
  assign pick_lsu = lsu_req && (!ifu_req || !last_lsu);

  assign ifu_addr_sel  = ifu_pend ? ifu_addr_q  : bus.ifu_addr;
  assign lsu_addr_sel  = lsu_pend ? lsu_addr_q  : bus.lsu_addr;
  assign lsu_size_sel  = lsu_pend ? lsu_size_q  : bus.lsu_size;
  assign lsu_wen_sel   = lsu_pend ? lsu_wen_q   : bus.lsu_wen;
  assign lsu_wdata_sel = lsu_pend ? lsu_wdata_q : bus.lsu_wdata;
  assign lsu_wmask_sel = lsu_pend ? lsu_wmask_q : bus.lsu_wmask;

  assign wait_done = bus.mem_respValid || (cnt == CNT_LAST);
  assign rsp_data  = bus.mem_respValid ? bus.mem_rdata : ERR_DATA;

  // Request fields only load while their side is free, so duplicates never disturb them.
  always_ff @(posedge clock) begin
    if (bus.ifu_reqValid && !ifu_pend) begin
      ifu_addr_q <= bus.ifu_addr;
    end
    if (bus.lsu_reqValid && !lsu_pend) begin
      lsu_addr_q  <= bus.lsu_addr;
      lsu_size_q  <= bus.lsu_size;
      lsu_wen_q   <= bus.lsu_wen;
      lsu_wdata_q <= bus.lsu_wdata;
      lsu_wmask_q <= bus.lsu_wmask;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ifu_pend    <= 1'b0;
      lsu_pend    <= 1'b0;
      last_lsu    <= 1'b0;
      gnt_lsu     <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_size_r  <= '0;
      mem_wen_r   <= 1'b0;
      mem_wdata_r <= '0;
      mem_wmask_r <= '0;
      ifu_resp_r  <= 1'b0;
      ifu_rdata_r <= '0;
      lsu_resp_r  <= 1'b0;
      lsu_rdata_r <= '0;
      bus_err_r   <= 1'b0;
    end else begin
      mem_req_r  <= 1'b0;
      ifu_resp_r <= 1'b0;
      lsu_resp_r <= 1'b0;

      if (grant && !pick_lsu)    ifu_pend <= 1'b0;
      else if (bus.ifu_reqValid) ifu_pend <= 1'b1;
      if (grant && pick_lsu)     lsu_pend <= 1'b0;
      else if (bus.lsu_reqValid) lsu_pend <= 1'b1;

      case (state)
        IDLE, RESP: begin
          if (grant) begin
            state     <= WAIT;
            cnt       <= '0;
            mem_req_r <= 1'b1;
            last_lsu  <= pick_lsu;
            gnt_lsu   <= pick_lsu;
            if (pick_lsu) begin
              mem_addr_r  <= lsu_addr_sel;
              mem_size_r  <= lsu_size_sel;
              mem_wen_r   <= lsu_wen_sel;
              mem_wdata_r <= lsu_wdata_sel;
              mem_wmask_r <= lsu_wmask_sel;
            end else begin
              mem_addr_r  <= ifu_addr_sel;
              mem_size_r  <= 2'd2;
              mem_wen_r   <= 1'b0;
              mem_wdata_r <= '0;
              mem_wmask_r <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_done) begin
            state <= RESP;
            if (!bus.mem_respValid) bus_err_r <= 1'b1;
            if (gnt_lsu) begin
              lsu_resp_r  <= 1'b1;
              lsu_rdata_r <= rsp_data;
            end else begin
              ifu_resp_r  <= 1'b1;
              ifu_rdata_r <= rsp_data;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_reqValid  = mem_req_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_size      = mem_size_r;
  assign bus.mem_wen       = mem_wen_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.mem_wmask     = mem_wmask_r;
  assign bus.ifu_respValid = ifu_resp_r;
  assign bus.ifu_rdata     = ifu_rdata_r;
  assign bus.lsu_respValid = lsu_resp_r;
  assign bus.lsu_rdata     = lsu_rdata_r;
  assign bus.bus_err       = bus_err_r;

endmodule
